// File: rtl/ga20_rom_arbiter.sv
// Two-requester arbiter for the shared 16-bit GA20 sample ROM port.
// The GA20 fetcher and the sound CPU each have a one-word hit buffer in front of the shared port.
module ga20_rom_arbiter #(
  parameter int ADDR_W = 20,
  parameter bit HIT_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              snd_rd_i,
  input  logic [ADDR_W-1:0] snd_addr_i,
  output logic [7:0]        snd_data_o,
  output logic              snd_valid_o,
  input  logic              cpu_rd_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [7:0]        cpu_data_o,
  output logic              cpu_valid_o,
  output logic              mem_req_o,
  output logic [ADDR_W-2:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [15:0]       mem_data_i
);

  localparam int TW = ADDR_W - 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e            state_q;
  logic              grant_q;
  logic              last_snd_q;
  logic              stale_q;
  logic              mem_req_q;
  logic [TW-1:0]     mem_addr_q;
  logic [ADDR_W-1:0] req_addr_q [2];
  logic [1:0]        pend_q;
  logic [1:0]        bvalid_q;
  logic [1:0]        valid_q;
  logic [TW-1:0]     tag_q [2];
  logic [15:0]       word_q [2];
  logic [7:0]        data_q [2];

  logic [1:0]        rd;
  logic [ADDR_W-1:0] addr [2];
  logic              ack_fire;
  logic              win_rd;
  logic              stale_now;
  logic              pick_cpu;
  logic [1:0]        ack_x;
  logic [1:0]        hit;
  logic [15:0]       eff_word [2];

  function automatic logic [7:0] sel_byte(input logic [15:0] w, input logic odd);
    return odd ? w[15:8] : w[7:0];
  endfunction

  // Index 0 is the GA20 fetcher, index 1 the CPU. A read arriving with the
  // ack for its own requester is looked up against the word being filled.
  always_comb begin
    rd        = {cpu_rd_i, snd_rd_i};
    addr[0]   = snd_addr_i;
    addr[1]   = cpu_addr_i;
    ack_fire  = (state_q == WAIT) && mem_ack_i;
    win_rd    = grant_q ? cpu_rd_i : snd_rd_i;
    stale_now = stale_q || win_rd;
    pick_cpu  = pend_q[1] && (!pend_q[0] || last_snd_q);
    for (int i = 0; i < 2; i++) begin
      ack_x[i]    = ack_fire && (grant_q == (i == 1));
      eff_word[i] = ack_x[i] ? mem_data_i : word_q[i];
      hit[i]      = HIT_EN && (ack_x[i] || bvalid_q[i]) &&
                    ((ack_x[i] ? mem_addr_q : tag_q[i]) == addr[i][ADDR_W-1:1]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_snd_q <= 1'b0;
      stale_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      pend_q     <= '0;
      bvalid_q   <= '0;
      valid_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        req_addr_q[i] <= '0;
        tag_q[i]      <= '0;
        word_q[i]     <= '0;
        data_q[i]     <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q != 2'b00) begin
            grant_q    <= pick_cpu;
            last_snd_q <= !pick_cpu;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          mem_req_q  <= 1'b1;
          mem_addr_q <= req_addr_q[grant_q][ADDR_W-1:1];
          stale_q    <= win_rd;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            stale_q <= stale_q || win_rd;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A stale ack still fills the buffer but leaves pend set so the newer address is fetched.
      for (int i = 0; i < 2; i++) begin
        if (ack_x[i]) begin
          tag_q[i]    <= mem_addr_q;
          word_q[i]   <= mem_data_i;
          bvalid_q[i] <= 1'b1;
        end
        if (rd[i]) begin
          req_addr_q[i] <= addr[i];
          if (hit[i]) begin
            data_q[i]  <= sel_byte(eff_word[i], addr[i][0]);
            valid_q[i] <= 1'b1;
            pend_q[i]  <= 1'b0;
          end else begin
            valid_q[i] <= 1'b0;
            pend_q[i]  <= 1'b1;
          end
        end else if (ack_x[i] && !stale_now) begin
          data_q[i]  <= sel_byte(mem_data_i, req_addr_q[i][0]);
          valid_q[i] <= 1'b1;
          pend_q[i]  <= 1'b0;
        end
      end
    end
  end

  assign snd_data_o  = data_q[0];
  assign snd_valid_o = valid_q[0];
  assign cpu_data_o  = data_q[1];
  assign cpu_valid_o = valid_q[1];
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;

endmodule
